// File: rtl/led_matrix_scheduler_if.sv
// rtl/led_matrix_scheduler_if.sv - host write/swap port of the LED matrix scheduler
// Ports (master = host, slave = scheduler):
//   wr_valid  host -> sched   write request
//   wr_ready  sched -> host   write accepted when wr_valid & wr_ready
//   wr_addr   host -> sched   {column[1:0], row[2:0]} in back buffer
//   wr_level  host -> sched   4-bit grey level, 0 = off, 15 = always on
//   swap_req  host -> sched   1-cycle pulse, swap at next frame boundary
//   swap_done sched -> host   1-cycle pulse on the edge the buffers swap
interface led_matrix_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [3:0] wr_level;
  logic       swap_req;
  logic       swap_done;

  modport master (
    output wr_valid, wr_addr, wr_level, swap_req,
    input  wr_ready, swap_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_level, swap_req,
    output wr_ready, swap_done
  );
endinterface

// File: rtl/led_matrix_scheduler.sv
// rtl/led_matrix_scheduler.sv - 4x8 multiplexed LED matrix scan controller with 16-level PWM
// Ports:
//   i_clock          in   system clock, posedge
//   i_reset_n        in   asynchronous active-low reset
//   host             slave modport of led_matrix_scheduler_if (writes + swap)
//   o_frame_start    out  1-cycle pulse on first blank cycle of column 0
//   o_column_enable  out  active-low one-cold column select
//   o_row_enable     out  active-low row drive, 0 = LED lit
module led_matrix_scheduler #(
  parameter int PWM_DIV      = 16,
  parameter int PWM_PERIODS  = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  led_matrix_scheduler_if.slave        host,
  output logic                         o_frame_start,
  output logic [3:0]                   o_column_enable,
  output logic [7:0]                   o_row_enable
);

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int PER_W = (PWM_PERIODS > 1) ? $clog2(PWM_PERIODS) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PWM_PERIODS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [BLK_W-1:0]  blank_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        step;
  logic [PER_W-1:0]  period_cnt;
  logic [1:0]        col;

  logic [3:0]        buf_a [32];
  logic [3:0]        buf_b [32];
  logic              front_sel;      // 0: buffer A on display, 1: buffer B
  logic              swap_pending;
  logic              swap_done_q;

  logic              blank_last;
  logic              step_tick;
  logic              step_wrap;
  logic              dwell_end;
  logic              swap_now;
  logic              wr_fire;
  logic [7:0]        row_lit;

  assign host.wr_ready  = ~swap_pending;
  assign host.swap_done = swap_done_q;
  assign wr_fire        = host.wr_valid & ~swap_pending;

  always_comb begin
    blank_last = (blank_cnt == BLK_LAST);
    step_tick  = (div_cnt == DIV_LAST);
    step_wrap  = step_tick && (step == 4'd14);
    dwell_end  = (state == ST_DRIVE) && step_wrap && (period_cnt == PER_LAST);
    // The frame boundary is the last DRIVE clock of column 3.
    swap_now   = dwell_end && (col == 2'd3) && swap_pending;
  end

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: if (blank_last) state_nxt = ST_DRIVE;
      ST_DRIVE: if (dwell_end)  state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase
  end

  // Scan counters: blank timer, PWM divider, PWM step, period count, column.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      blank_cnt  <= '0;
      div_cnt    <= '0;
      step       <= '0;
      period_cnt <= '0;
      col        <= '0;
    end else if (state == ST_BLANK) begin
      blank_cnt <= blank_last ? '0 : blank_cnt + 1'b1;
    end else begin
      div_cnt <= step_tick ? '0 : div_cnt + 1'b1;
      if (step_tick) begin
        step <= (step == 4'd14) ? 4'd0 : step + 4'd1;
      end
      if (step_wrap) begin
        period_cnt <= dwell_end ? '0 : period_cnt + 1'b1;
      end
      if (dwell_end) begin
        col <= col + 2'd1;
      end
    end
  end

  // Frame buffers; only the back buffer is ever written.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 32; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else if (wr_fire) begin
      if (front_sel) begin
        buf_a[host.wr_addr] <= host.wr_level;
      end else begin
        buf_b[host.wr_addr] <= host.wr_level;
      end
    end
  end

  // Swap handshake. A request arriving on the swap edge re-arms the pending flag.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      swap_done_q <= swap_now;
      if (swap_now) begin
        front_sel    <= ~front_sel;
        swap_pending <= host.swap_req;
      end else if (host.swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Row r is lit while the PWM step is below its level, giving L/15 duty.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      row_lit[r] = front_sel ? (step < buf_b[{col, 3'(r)}])
                             : (step < buf_a[{col, 3'(r)}]);
    end
  end

  // Registered pin drive, one clock behind the decoded scan state.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_column_enable <= 4'hF;
      o_row_enable    <= 8'hFF;
      o_frame_start   <= 1'b0;
    end else begin
      o_column_enable <= (state == ST_DRIVE) ? ~(4'b0001 << col) : 4'hF;
      o_row_enable    <= (state == ST_DRIVE) ? ~row_lit : 8'hFF;
      o_frame_start   <= (state == ST_BLANK) && (col == 2'd0) && (blank_cnt == '0);
    end
  end

endmodule
